div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider. Serves DIV/DIVU in the EX stage.
- It is the producing end of the pipeline's multi-cycle stall handshake. It raises `choke` while a division is in flight and pulses `return_ready` when the result is valid.
- Hazard logic consumes these signals to hold IF/ID and bubble ID/EX. `quotient` feeds LO and `remainder` feeds HI.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  launch a division; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  operand A; sampled with start.
- divisor  input  WIDTH  operand B; sampled with start.
- flush  input  1  cancel any in-flight operation (exception/eret).
- choke  output  1  stall request to hazard logic.
- return_ready  output  1  one-cycle pulse; result valid this cycle.
- quotient  output  WIDTH  result to LO.
- remainder  output  WIDTH  result to HI.

Behaviour:
- Single clock `clk`. Reset `resetn` is asynchronous and active-low.
- Reset values: state=IDLE, choke=0, return_ready=0, quotient=0, remainder=0, iteration counter=0, internal operand registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 → latch sign flags, magnitudes |A| and |B| (the signed case uses the two's-complement absolute value), a divisor-zero flag, and counter=0. Go to CALC.
  - Otherwise stay in IDLE.
- CALC: one quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits. Shift left, bring in the next dividend bit, then trial-subtract |B|.
  - Non-negative trial → keep the difference and set quotient bit to 1. Negative → restore and set the bit to 0.
  - After the WIDTH-th iteration (counter==WIDTH-1) go to DONE.
- DONE: register final results and drive return_ready=1 for exactly this cycle. Next state is IDLE.
- Sign fix (signed and divisor≠0 only):
  - Quotient is negated if sign(A)≠sign(B).
  - Remainder takes the sign of A and is negated if A<0.
- Divisor zero, signed or unsigned: quotient = all ones, remainder = dividend (raw input value). Sign fix is bypassed. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. This falls out naturally from magnitude arithmetic.
- choke:
  - Combinational: choke = (IDLE & start & ~flush) | CALC.
  - It is 0 in DONE, so the stall releases in the same cycle the result becomes visible.
- Latency: start sampled in cycle T.
  - choke is high in cycles T..T+WIDTH.
  - return_ready is high in cycle T+WIDTH+1 only.
- quotient/remainder hold their last result until the next DONE. They are not cleared by start or flush.
- start while in CALC or DONE is ignored. No queuing.
- flush:
  - Any state → IDLE on the next edge. No return_ready is produced and outputs keep their previous values.
  - If flush is high in DONE, that cycle's return_ready is suppressed (forced 0) and results are not updated.
  - start and flush in the same IDLE cycle: flush wins, nothing launches, and choke stays 0.
- Reset asserted mid-operation: immediate return to reset values, with no residual return_ready after release.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.

Test Plan:
- Unsigned: start at T with is_signed=0, A=100, B=7 → choke high T..T+32; at T+33 return_ready=1, quotient=14, remainder=2; choke=0 at T+33.
- Signed: A=0xFFFFFFF9 (-7), B=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also A=0x80000000, B=0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero:
  - Unsigned A=5, B=0 → quotient=0xFFFFFFFF, remainder=5 at T+33.
  - Signed A=0xFFFFFFF6, B=0 → quotient=0xFFFFFFFF, remainder=0xFFFFFFF6.
- Flush: start at T, flush at T+10 → choke low from T+11 and no return_ready through T+40; outputs hold the previous result. Start at T+12 completes normally at T+45.
- Ignored/simultaneous starts:
  - start pulsed at T+5 during CALC → no effect, single return_ready at T+33.
  - start and flush together in IDLE → choke stays 0 and no operation runs.
- Reset: resetn low at T+20 during CALC → all outputs 0 immediately. After release, no return_ready until a fresh start, which completes 33 cycles later.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result valid WIDTH+1 cycles after start.
// No input backpressure: choke stalls the pipeline while busy, and starts outside IDLE are dropped.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             choke,
  output logic             return_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] aq;        // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] q_hold;
  logic [WIDTH-1:0] r_hold;
  logic             neg_q;
  logic             neg_r;
  logic             dvs_zero;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
  end

  // The partial remainder is always below |B|, so WIDTH bits hold it; the trial needs one more for the sign.
  always_comb begin
    trial = {rem, aq[WIDTH-1]} - {1'b0, dvs};
  end

  always_comb begin
    fin_q = aq;
    fin_r = rem;
    if (dvs_zero) begin
      fin_q = '1;
      fin_r = raw_a;
    end else begin
      if (neg_q) fin_q = ~aq + 1'b1;
      if (neg_r) fin_r = ~rem + 1'b1;
    end
  end

  always_comb begin
    choke        = ((state == IDLE) & start & ~flush) | (state == CALC);
    return_ready = (state == DONE) & ~flush;
    quotient     = return_ready ? fin_q : q_hold;
    remainder    = return_ready ? fin_r : r_hold;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      aq       <= '0;
      dvs      <= '0;
      rem      <= '0;
      raw_a    <= '0;
      q_hold   <= '0;
      r_hold   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvs_zero <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aq       <= a_mag;
            dvs      <= b_mag;
            rem      <= '0;
            raw_a    <= dividend;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            dvs_zero <= (divisor == '0);
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (trial[WIDTH]) begin
            rem <= {rem[WIDTH-2:0], aq[WIDTH-1]};
          end else begin
            rem <= trial[WIDTH-1:0];
          end
          aq  <= {aq[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          q_hold <= fin_q;
          r_hold <= fin_r;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random divisions against an arithmetic reference, with cycle-exact stall/ready timing.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        choke;
  logic        return_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int          n_err;
  int          n_checks;
  logic [31:0] exp_q_hold;
  logic [31:0] exp_r_hold;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .is_signed    (is_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .choke        (choke),
    .return_ready (return_ready),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_choke", {31'd0, choke}, 32'd0);
      chk("idle_ready", {31'd0, return_ready}, 32'd0);
      chk("idle_q_hold", quotient, exp_q_hold);
      chk("idle_r_hold", remainder, exp_r_hold);
      tick();
    end
  endtask

  // Entered and left just after a rising edge. flush_at/poke_at are cycle offsets from the start cycle, -1 = none.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int poke_at);
    logic [31:0] eq;
    logic [31:0] er;
    model(s, a, b, eq, er);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    flush     = (flush_at == 0);
    @(negedge clk);
    if (flush_at == 0) begin
      chk("sf_choke", {31'd0, choke}, 32'd0);
      chk("sf_ready", {31'd0, return_ready}, 32'd0);
      tick();
      start = 1'b0;
      flush = 1'b0;
      idle(3);
      return;
    end
    chk("start_choke", {31'd0, choke}, 32'd1);
    chk("start_ready", {31'd0, return_ready}, 32'd0);
    tick();
    for (int c = 1; c <= 33; c++) begin
      start     = (c == poke_at);
      flush     = (c == flush_at);
      is_signed = $urandom_range(0, 1);
      dividend  = $urandom;
      divisor   = $urandom;
      @(negedge clk);
      if (c <= 32) begin
        chk("calc_choke", {31'd0, choke}, 32'd1);
        chk("calc_ready", {31'd0, return_ready}, 32'd0);
        chk("calc_q_hold", quotient, exp_q_hold);
        chk("calc_r_hold", remainder, exp_r_hold);
      end else if (flush_at == 33) begin
        chk("doneflush_ready", {31'd0, return_ready}, 32'd0);
        chk("doneflush_choke", {31'd0, choke}, 32'd0);
        chk("doneflush_q", quotient, exp_q_hold);
        chk("doneflush_r", remainder, exp_r_hold);
      end else begin
        chk("done_ready", {31'd0, return_ready}, 32'd1);
        chk("done_choke", {31'd0, choke}, 32'd0);
        chk("done_quotient", quotient, eq);
        chk("done_remainder", remainder, er);
        exp_q_hold = eq;
        exp_r_hold = er;
      end
      tick();
      if (c == flush_at) begin
        start = 1'b0;
        flush = 1'b0;
        idle(1);
        return;
      end
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    n_err      = 0;
    n_checks   = 0;
    exp_q_hold = 32'd0;
    exp_r_hold = 32'd0;
    resetn     = 1'b0;
    start      = 1'b0;
    is_signed  = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    flush      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_choke", {31'd0, choke}, 32'd0);
    chk("rst_ready", {31'd0, return_ready}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    resetn = 1'b1;
    tick();
    idle(2);

    run_op(1'b0, 32'd100, 32'd7, -1, -1);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(1'b0, 32'd5, 32'd0, -1, -1);
    run_op(1'b1, 32'hFFFF_FFF6, 32'd0, -1, -1);
    run_op(1'b0, 32'd1000, 32'd33, -1, 5);
    run_op(1'b1, 32'd12345, 32'hFFFF_FFEF, 10, -1);
    run_op(1'b0, 32'd77, 32'd5, -1, -1);
    run_op(1'b0, 32'd9, 32'd3, 0, -1);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 33, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 33);
    run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, -1, -1);

    // Reset in the middle of a division.
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    tick();
    start = 1'b0;
    repeat (19) tick();
    resetn = 1'b0;
    #1;
    chk("midrst_choke", {31'd0, choke}, 32'd0);
    chk("midrst_ready", {31'd0, return_ready}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    exp_q_hold = 32'd0;
    exp_r_hold = 32'd0;
    #2;
    resetn = 1'b1;
    tick();
    idle(40);
    run_op(1'b0, 32'd1000, 32'd3, -1, -1);

    for (int i = 0; i < 24; i++) begin
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      s   = $urandom_range(0, 1);
      a   = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (sel == 2) a = 32'h8000_0000;
      run_op(s, a, b, -1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : -1);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
